// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong sequencer: moves ball and paddles once per frame_tick,
// resolves wall/paddle collisions, keeps score and runs serve/play/game-over.
module pong_game_ctrl #(
    parameter int H_DISPLAY    = 640,
    parameter int V_DISPLAY    = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_L_X   = 16,
    parameter int PADDLE_R_X   = 616,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       up_l,
    input  logic       dn_l,
    input  logic       up_r,
    input  logic       dn_r,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_l_y,
    output logic [9:0] paddle_r_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [2:0] state,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        SCORE     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam int CW = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0] BALL_X0    = 10'((H_DISPLAY - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y0    = 10'((V_DISPLAY - BALL_SIZE) / 2);
    localparam logic [9:0] PAD_Y0     = 10'((V_DISPLAY - PADDLE_H) / 2);
    localparam logic [9:0] PAD_Y_MAX  = 10'(V_DISPLAY - PADDLE_H);
    localparam logic [9:0] BALL_X_MAX = 10'(H_DISPLAY - BALL_SIZE);
    localparam logic [9:0] BALL_Y_MAX = 10'(V_DISPLAY - BALL_SIZE);
    localparam logic [9:0] L_FACE     = 10'(PADDLE_L_X + PADDLE_W);
    localparam logic [9:0] R_FACE     = 10'(PADDLE_R_X);
    localparam logic [9:0] R_STOP     = 10'(PADDLE_R_X - BALL_SIZE);
    localparam logic [9:0] B_SPD      = 10'(BALL_SPEED);
    localparam logic [9:0] P_SPD      = 10'(PADDLE_SPEED);
    localparam logic [9:0] B_SZ       = 10'(BALL_SIZE);
    localparam logic [9:0] P_H        = 10'(PADDLE_H);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);
    localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_FRAMES - 1);

    state_t          state_q, state_nxt;
    logic [9:0]      ball_x_nxt, ball_y_nxt, paddle_l_nxt, paddle_r_nxt;
    logic [3:0]      score_l_nxt, score_r_nxt;
    logic [CW-1:0]   serve_cnt, serve_cnt_nxt;
    logic            dir_x, dir_x_nxt;
    logic            dir_y, dir_y_nxt;
    logic            game_over_nxt;
    logic            overlap_l, overlap_r, hit_l, hit_r;

    // Up/down with clamping at the screen edges; conflicting buttons hold.
    function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up, input logic dn);
        paddle_step = y;
        if (up && !dn)
            paddle_step = (y <= P_SPD) ? 10'd0 : y - P_SPD;
        else if (dn && !up)
            paddle_step = (y >= PAD_Y_MAX - P_SPD) ? PAD_Y_MAX : y + P_SPD;
    endfunction

    assign overlap_l = (ball_y + B_SZ > paddle_l_y) && (ball_y < paddle_l_y + P_H);
    assign overlap_r = (ball_y + B_SZ > paddle_r_y) && (ball_y < paddle_r_y + P_H);
    assign hit_l     = (ball_x >= L_FACE) && (ball_x - B_SPD <= L_FACE) && overlap_l;
    assign hit_r     = (ball_x + B_SZ <= R_FACE) && (ball_x + B_SPD + B_SZ >= R_FACE) && overlap_r;

    always_comb begin
        state_nxt     = state_q;
        ball_x_nxt    = ball_x;
        ball_y_nxt    = ball_y;
        paddle_l_nxt  = paddle_l_y;
        paddle_r_nxt  = paddle_r_y;
        score_l_nxt   = score_l;
        score_r_nxt   = score_r;
        serve_cnt_nxt = serve_cnt;
        dir_x_nxt     = dir_x;
        dir_y_nxt     = dir_y;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt     = SERVE;
                    score_l_nxt   = 4'd0;
                    score_r_nxt   = 4'd0;
                    serve_cnt_nxt = SERVE_LOAD;
                    ball_x_nxt    = BALL_X0;
                    ball_y_nxt    = BALL_Y0;
                    paddle_l_nxt  = PAD_Y0;
                    paddle_r_nxt  = PAD_Y0;
                end
            end

            SERVE: begin
                if (frame_tick) begin
                    paddle_l_nxt = paddle_step(paddle_l_y, up_l, dn_l);
                    paddle_r_nxt = paddle_step(paddle_r_y, up_r, dn_r);
                    ball_x_nxt   = BALL_X0;
                    ball_y_nxt   = BALL_Y0;
                    if (serve_cnt == '0)
                        state_nxt = PLAY;
                    else
                        serve_cnt_nxt = serve_cnt - 1'b1;
                end
            end

            PLAY: begin
                if (frame_tick) begin
                    paddle_l_nxt = paddle_step(paddle_l_y, up_l, dn_l);
                    paddle_r_nxt = paddle_step(paddle_r_y, up_r, dn_r);

                    if (dir_y) begin
                        if (ball_y + B_SPD >= BALL_Y_MAX) begin
                            ball_y_nxt = BALL_Y_MAX;
                            dir_y_nxt  = 1'b0;
                        end else begin
                            ball_y_nxt = ball_y + B_SPD;
                        end
                    end else if (ball_y <= B_SPD) begin
                        ball_y_nxt = 10'd0;
                        dir_y_nxt  = 1'b1;
                    end else begin
                        ball_y_nxt = ball_y - B_SPD;
                    end

                    // A paddle hit takes priority over the miss test on the same side.
                    if (!dir_x) begin
                        if (hit_l) begin
                            ball_x_nxt = L_FACE;
                            dir_x_nxt  = 1'b1;
                        end else if (ball_x <= B_SPD) begin
                            ball_x_nxt = 10'd0;
                            if (score_r < WIN)
                                score_r_nxt = score_r + 4'd1;
                            state_nxt = SCORE;
                        end else begin
                            ball_x_nxt = ball_x - B_SPD;
                        end
                    end else begin
                        if (hit_r) begin
                            ball_x_nxt = R_STOP;
                            dir_x_nxt  = 1'b0;
                        end else if (ball_x + B_SPD >= BALL_X_MAX) begin
                            ball_x_nxt = BALL_X_MAX;
                            if (score_l < WIN)
                                score_l_nxt = score_l + 4'd1;
                            state_nxt = SCORE;
                        end else begin
                            ball_x_nxt = ball_x + B_SPD;
                        end
                    end
                end
            end

            SCORE: begin
                if (frame_tick) begin
                    if (score_l == WIN || score_r == WIN) begin
                        state_nxt = GAME_OVER;
                    end else begin
                        // The ball rests at x=0 after a left miss, so serve back toward the left.
                        dir_x_nxt     = (ball_x != 10'd0);
                        ball_x_nxt    = BALL_X0;
                        ball_y_nxt    = BALL_Y0;
                        serve_cnt_nxt = SERVE_LOAD;
                        state_nxt     = SERVE;
                    end
                end
            end

            GAME_OVER: begin
                if (start) begin
                    state_nxt     = SERVE;
                    score_l_nxt   = 4'd0;
                    score_r_nxt   = 4'd0;
                    serve_cnt_nxt = SERVE_LOAD;
                    ball_x_nxt    = BALL_X0;
                    ball_y_nxt    = BALL_Y0;
                    paddle_l_nxt  = PAD_Y0;
                    paddle_r_nxt  = PAD_Y0;
                end
            end

            default: state_nxt = IDLE;
        endcase

        game_over_nxt = (state_nxt == GAME_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ball_x     <= BALL_X0;
            ball_y     <= BALL_Y0;
            paddle_l_y <= PAD_Y0;
            paddle_r_y <= PAD_Y0;
            score_l    <= 4'd0;
            score_r    <= 4'd0;
            serve_cnt  <= '0;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            game_over  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            ball_x     <= ball_x_nxt;
            ball_y     <= ball_y_nxt;
            paddle_l_y <= paddle_l_nxt;
            paddle_r_y <= paddle_r_nxt;
            score_l    <= score_l_nxt;
            score_r    <= score_r_nxt;
            serve_cnt  <= serve_cnt_nxt;
            dir_x      <= dir_x_nxt;
            dir_y      <= dir_y_nxt;
            game_over  <= game_over_nxt;
        end
    end

    assign state = state_q;

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Frame-rate game sequencer for the Pong display path.
- Once per video frame, during vertical blank, it updates the ball and paddle positions, resolves wall and paddle collisions, keeps score and runs the serve/play/game-over sequence.
- Its position outputs feed the pixel renderer that drives rgb from the VGA timing generator's pixel coordinates.
- The timing generator supplies frame_tick.

Parameters:
H_DISPLAY, 640, visible width in pixels
V_DISPLAY, 480, visible height in pixels
BALL_SIZE, 8, ball edge length in pixels (square)
PADDLE_W, 8, paddle width
PADDLE_H, 64, paddle height
PADDLE_L_X, 16, left paddle x (left edge)
PADDLE_R_X, 616, right paddle x (left edge)
BALL_SPEED, 2, ball step per frame on each axis
PADDLE_SPEED, 4, paddle step per frame
WIN_SCORE, 7, points needed to win
SERVE_FRAMES, 60, frames the ball is held before play

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
frame_tick  input  1  single-cycle pulse, once per frame at start of vertical blank
start  input  1  level; starts or restarts a game
up_l  input  1  left paddle up
dn_l  input  1  left paddle down
up_r  input  1  right paddle up
dn_r  input  1  right paddle down
ball_x  output  10  ball left edge
ball_y  output  10  ball top edge
paddle_l_y  output  10  left paddle top edge
paddle_r_y  output  10  right paddle top edge
score_l  output  4  left player score
score_r  output  4  right player score
state  output  3  IDLE=0, SERVE=1, PLAY=2, SCORE=3, GAME_OVER=4
game_over  output  1  high in GAME_OVER

Behaviour:
Reset values:
- Reset is asynchronous and acts immediately from any state.
- state=IDLE. ball=(316,236), which is (H_DISPLAY-BALL_SIZE)/2, (V_DISPLAY-BALL_SIZE)/2.
- Both paddles at y=208, which is (V_DISPLAY-PADDLE_H)/2.
- Scores 0, game_over=0, dir_x=+1 (right), dir_y=+1 (down), serve counter 0.

Update timing:
- All registers are registered outputs.
- Position, score and serve-counter updates occur only on a clk edge with frame_tick=1.
- State transitions out of IDLE and GAME_OVER are driven by start on any cycle.

FSM:
- IDLE: start=1 -> SERVE next clock. Scores are cleared and the counter is loaded with SERVE_FRAMES-1.
- SERVE: the ball is held centred. On each tick, counter==0 -> PLAY, else counter decrements. The ball stays held for exactly SERVE_FRAMES ticks.
- PLAY: on each tick the ball and paddles move as described below. A miss -> SCORE.
- SCORE: lasts one tick.
  - If the updated score equals WIN_SCORE -> GAME_OVER.
  - Otherwise ball is recentred, dir_x points toward the player who conceded, dir_y is kept, counter is reloaded, -> SERVE.
- GAME_OVER: game_over=1; ball and paddles frozen. start=1 -> scores cleared, ball and paddles reset to their reset positions, counter loaded -> SERVE.

Paddles (SERVE and PLAY only):
- up only: y -= PADDLE_SPEED, clamped at 0.
- dn only: y += PADDLE_SPEED, clamped at V_DISPLAY-PADDLE_H (416).
- Both or neither pressed: hold.

Ball in PLAY. All collision checks use the pre-update ball and paddle values.
- Vertical, moving down: if ball_y+BALL_SPEED >= V_DISPLAY-BALL_SIZE, set y=472 and flip to up. Otherwise y += BALL_SPEED.
- Vertical, moving up: if ball_y <= BALL_SPEED, set y=0 and flip to down. Otherwise y -= BALL_SPEED.
- Vertical overlap with a paddle means: ball_y+BALL_SIZE > pad_y and ball_y < pad_y+PADDLE_H.
- Moving left, left-paddle hit:
  - Condition: ball_x >= PADDLE_L_X+PADDLE_W (24), ball_x-BALL_SPEED <= 24, and vertical overlap with the left paddle.
  - Action: x=24, dir_x flips to right.
- Moving left, miss: otherwise, if ball_x <= BALL_SPEED, then x=0, score_r increments, -> SCORE.
- Moving right, right-paddle hit:
  - Condition: ball_x+BALL_SIZE <= PADDLE_R_X, ball_x+BALL_SPEED+BALL_SIZE >= 616, and vertical overlap with the right paddle.
  - Action: x=608, dir_x flips to left.
- Moving right, miss: otherwise, if ball_x+BALL_SPEED >= H_DISPLAY-BALL_SIZE (632), then x=632, score_l increments, -> SCORE.
- Horizontal and vertical updates apply in the same tick.
- A corner hit flips both directions.

Other rules:
- Scores saturate at WIN_SCORE. Width 4 requires WIN_SCORE <= 15.
- start held high in SERVE or PLAY is ignored.
- frame_tick held high for several cycles produces one update per cycle. This is the source's contract, not checked here.

Test Plan:
- Reset check: assert rst mid-PLAY -> outputs return immediately to ball (316,236), paddles 208/208, scores 0/0, state 0, game_over 0.
- Serve timing: pulse start, then 60 frame_ticks -> state 1 through tick 59 with ball at (316,236). Tick 60 -> state 2. First PLAY tick -> ball (318,238).
- Paddle clamp and conflict: hold up_l for 60 ticks in PLAY -> paddle_l_y 208→0, stays 0. Hold dn_r 200 ticks -> paddle_r_y 416. up_l and dn_l together -> no change.
- Wall bounce: ball moving down from y=470 -> y=472 with dir up. Next tick -> y=470.
- Paddle hit and miss:
  - Right paddle at 208, ball moving right at (606,240) -> x=608, dir_x left.
  - Left paddle at 0, ball moving left at (2,300) -> x=0, score_r=1, SCORE for one tick, then SERVE with ball (316,236) and dir_x left.
- Game over: preload score_r=6, force a left miss -> score_r=7, state 4, game_over=1. Ball frozen over 10 ticks. start -> scores 0/0, state 1.
